// File: rtl/core_defs.sv
// Shared core definitions: ROB id geometry, destination encoding and the renamed-operand bundle.
package core_defs;

    localparam int unsigned ROB_IDW  = 8;
    localparam int unsigned ROB_IDXW = 7;
    localparam int unsigned NO_RD    = 5;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned AREGW    = 5;
    localparam int unsigned RDW      = 6;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tagval;
    } opnd_t;

    // Wake a waiting operand when a good writeback carries its producer tag.
    function automatic opnd_t opnd_wake(input opnd_t o, input logic wb_en,
                                        input logic [ROB_IDXW-1:0] wb_idx,
                                        input logic [XLEN-1:0] wb_res);
        opnd_t r;
        r = o;
        if (!o.valid && wb_en && (o.tagval[ROB_IDXW-1:0] == wb_idx)) begin
            r.valid  = 1'b1;
            r.tagval = wb_res;
        end
        return r;
    endfunction

endpackage

// File: rtl/rename_buf.sv
// Two-entry FIFO of renamed instructions; waiting operands snoop the writeback bus every cycle.
module rename_buf
    import core_defs::*;
#(
    parameter int unsigned OPW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [OPW-1:0]      push_op_i,
    input  logic [XLEN-1:0]     push_imm_i,
    input  logic [RDW-1:0]      push_rd_i,
    input  logic [ROB_IDW-1:0]  push_robid_i,
    input  opnd_t               push_rs1_i,
    input  opnd_t               push_rs2_i,
    input  logic                pop_i,
    input  logic                wb_en_i,
    input  logic [ROB_IDXW-1:0] wb_idx_i,
    input  logic [XLEN-1:0]     wb_result_i,
    output logic [1:0]          count_o,
    output logic                head_valid_o,
    output logic [OPW-1:0]      head_op_o,
    output logic [XLEN-1:0]     head_imm_o,
    output logic [RDW-1:0]      head_rd_o,
    output logic [ROB_IDW-1:0]  head_robid_o,
    output opnd_t               head_rs1_o,
    output opnd_t               head_rs2_o
);

    logic [OPW-1:0]     op_q    [2];
    logic [OPW-1:0]     op_d    [2];
    logic [XLEN-1:0]    imm_q   [2];
    logic [XLEN-1:0]    imm_d   [2];
    logic [RDW-1:0]     rd_q    [2];
    logic [RDW-1:0]     rd_d    [2];
    logic [ROB_IDW-1:0] robid_q [2];
    logic [ROB_IDW-1:0] robid_d [2];
    opnd_t              rs1_q   [2];
    opnd_t              rs1_d   [2];
    opnd_t              rs2_q   [2];
    opnd_t              rs2_d   [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;

    // Wakeup first, then a push overwrites the tail slot; flush wins over everything.
    always_comb begin
        op_d     = op_q;
        imm_d    = imm_q;
        rd_d     = rd_q;
        robid_d  = robid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + 2'(push_i) - 2'(pop_i);
        for (int i = 0; i < 2; i++) begin
            rs1_d[i] = opnd_wake(rs1_q[i], wb_en_i, wb_idx_i, wb_result_i);
            rs2_d[i] = opnd_wake(rs2_q[i], wb_en_i, wb_idx_i, wb_result_i);
        end
        if (push_i) begin
            op_d[wr_ptr_q]    = push_op_i;
            imm_d[wr_ptr_q]   = push_imm_i;
            rd_d[wr_ptr_q]    = push_rd_i;
            robid_d[wr_ptr_q] = push_robid_i;
            rs1_d[wr_ptr_q]   = push_rs1_i;
            rs2_d[wr_ptr_q]   = push_rs2_i;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (flush_i) begin
            op_d     = '{default: '0};
            imm_d    = '{default: '0};
            rd_d     = '{default: '0};
            robid_d  = '{default: '0};
            rs1_d    = '{default: '0};
            rs2_d    = '{default: '0};
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '{default: '0};
            imm_q    <= '{default: '0};
            rd_q     <= '{default: '0};
            robid_q  <= '{default: '0};
            rs1_q    <= '{default: '0};
            rs2_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            op_q     <= op_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            robid_q  <= robid_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_op_o    = op_q[rd_ptr_q];
    assign head_imm_o   = imm_q[rd_ptr_q];
    assign head_rd_o    = rd_q[rd_ptr_q];
    assign head_robid_o = robid_q[rd_ptr_q];
    assign head_rs1_o   = rs1_q[rd_ptr_q];
    assign head_rs2_o   = rs2_q[rd_ptr_q];

endmodule

// File: rtl/rename_stage.sv
// Rename stage: ROB id/credit allocation, RAT access, in-flight slot and 2-entry wakeup buffer.
// Optional x0 handling is enabled with `define ZERO_REG_EN.
module rename_stage
    import core_defs::*;
#(
    parameter int unsigned ROB_DEPTH = 128,
    parameter int unsigned OPW       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                decode_rename_valid,
    input  logic [OPW-1:0]      decode_rename_op,
    input  logic [AREGW-1:0]    decode_rename_rs1,
    input  logic [AREGW-1:0]    decode_rename_rs2,
    input  logic [RDW-1:0]      decode_rename_rd,
    input  logic [XLEN-1:0]     decode_rename_imm,
    output logic                rename_stall,
    output logic                rename_rat_valid,
    output logic [RDW-1:0]      rename_rat_rd,
    output logic [ROB_IDW-1:0]  rename_rat_robid,
    output logic [AREGW-1:0]    rename_rat_rs1,
    output logic [AREGW-1:0]    rename_rat_rs2,
    input  logic                rat_rs1_valid,
    input  logic [XLEN-1:0]     rat_rs1_tagval,
    input  logic                rat_rs2_valid,
    input  logic [XLEN-1:0]     rat_rs2_tagval,
    input  logic                wb_valid,
    input  logic                wb_error,
    input  logic [ROB_IDW-1:0]  wb_robid,
    input  logic [XLEN-1:0]     wb_result,
    input  logic                rob_flush,
    input  logic                rob_ret_valid,
    output logic                rename_dispatch_valid,
    output logic [OPW-1:0]      rename_dispatch_op,
    output logic [XLEN-1:0]     rename_dispatch_imm,
    output logic [RDW-1:0]      rename_dispatch_rd,
    output logic [ROB_IDW-1:0]  rename_dispatch_robid,
    output logic                rename_dispatch_rs1_valid,
    output logic [XLEN-1:0]     rename_dispatch_rs1_tagval,
    output logic                rename_dispatch_rs2_valid,
    output logic [XLEN-1:0]     rename_dispatch_rs2_tagval,
    input  logic                dispatch_stall
);

    localparam int unsigned CRW = $clog2(ROB_DEPTH + 1);

    logic [ROB_IDW-1:0]  tail_q, tail_d;
    logic [CRW-1:0]      credits_q, credits_d;
    logic                ifl_valid_q, ifl_valid_d;
    logic [OPW-1:0]      ifl_op_q, ifl_op_d;
    logic [XLEN-1:0]     ifl_imm_q, ifl_imm_d;
    logic [RDW-1:0]      ifl_rd_q, ifl_rd_d;
    logic [ROB_IDW-1:0]  ifl_robid_q, ifl_robid_d;
    logic                ifl_rs1_zero_q, ifl_rs1_zero_d;
    logic                ifl_rs2_zero_q, ifl_rs2_zero_d;
    logic                ifl_wb_en_q, ifl_wb_en_d;
    logic [ROB_IDXW-1:0] ifl_wb_idx_q, ifl_wb_idx_d;
    logic [XLEN-1:0]     ifl_wb_res_q, ifl_wb_res_d;

    logic                wb_en, pop, accept, buf_valid;
    logic                rs1_zero, rs2_zero, rd_zero;
    logic [1:0]          buf_count, occ;
    opnd_t               cap_rs1, cap_rs2, head_rs1, head_rs2;
    logic                wb_phase_unused;

    assign wb_phase_unused = wb_robid[ROB_IDW-1];

`ifdef ZERO_REG_EN
    assign rs1_zero = (decode_rename_rs1 == '0);
    assign rs2_zero = (decode_rename_rs2 == '0);
    assign rd_zero  = (decode_rename_rd == '0);
`else
    assign rs1_zero = 1'b0;
    assign rs2_zero = 1'b0;
    assign rd_zero  = 1'b0;
`endif

    assign wb_en  = wb_valid & ~wb_error;
    assign pop    = buf_valid & ~dispatch_stall;
    assign occ    = buf_count + 2'(ifl_valid_q);
    assign rename_stall = rst | rob_flush | (credits_q == '0) | ((occ == 2'd2) & ~pop);
    assign accept = decode_rename_valid & ~rename_stall;

    assign rename_rat_valid = accept & ~decode_rename_rd[NO_RD] & ~rd_zero;
    assign rename_rat_rd    = rst ? '0 : decode_rename_rd;
    assign rename_rat_robid = rst ? '0 : tail_q;
    assign rename_rat_rs1   = rst ? '0 : decode_rename_rs1;
    assign rename_rat_rs2   = rst ? '0 : decode_rename_rs2;

    // RAT result arriving in N+1, woken by the wb latched in N or the one present now.
    always_comb begin
        cap_rs1 = rat_rs1_valid ? '{valid: 1'b1, tagval: rat_rs1_tagval}
                                : '{valid: 1'b0, tagval: XLEN'(rat_rs1_tagval[ROB_IDXW-1:0])};
        cap_rs2 = rat_rs2_valid ? '{valid: 1'b1, tagval: rat_rs2_tagval}
                                : '{valid: 1'b0, tagval: XLEN'(rat_rs2_tagval[ROB_IDXW-1:0])};
        cap_rs1 = opnd_wake(cap_rs1, ifl_wb_en_q, ifl_wb_idx_q, ifl_wb_res_q);
        cap_rs2 = opnd_wake(cap_rs2, ifl_wb_en_q, ifl_wb_idx_q, ifl_wb_res_q);
        cap_rs1 = opnd_wake(cap_rs1, wb_en, wb_robid[ROB_IDXW-1:0], wb_result);
        cap_rs2 = opnd_wake(cap_rs2, wb_en, wb_robid[ROB_IDXW-1:0], wb_result);
        if (ifl_rs1_zero_q) begin
            cap_rs1 = '{valid: 1'b1, tagval: '0};
        end
        if (ifl_rs2_zero_q) begin
            cap_rs2 = '{valid: 1'b1, tagval: '0};
        end
    end

    always_comb begin
        tail_d         = tail_q + ROB_IDW'(accept);
        credits_d      = credits_q;
        ifl_valid_d    = accept;
        ifl_op_d       = ifl_op_q;
        ifl_imm_d      = ifl_imm_q;
        ifl_rd_d       = ifl_rd_q;
        ifl_robid_d    = ifl_robid_q;
        ifl_rs1_zero_d = ifl_rs1_zero_q;
        ifl_rs2_zero_d = ifl_rs2_zero_q;
        ifl_wb_en_d    = wb_en;
        ifl_wb_idx_d   = wb_robid[ROB_IDXW-1:0];
        ifl_wb_res_d   = wb_result;
        if (accept) begin
            ifl_op_d       = decode_rename_op;
            ifl_imm_d      = decode_rename_imm;
            ifl_rd_d       = {decode_rename_rd[NO_RD] | rd_zero, decode_rename_rd[NO_RD-1:0]};
            ifl_robid_d    = tail_q;
            ifl_rs1_zero_d = rs1_zero;
            ifl_rs2_zero_d = rs2_zero;
        end
        if (rob_ret_valid && !accept && (credits_q < CRW'(ROB_DEPTH))) begin
            credits_d = credits_q + CRW'(1);
        end else if (accept && !rob_ret_valid) begin
            credits_d = credits_q - CRW'(1);
        end
        if (rob_flush) begin
            tail_d      = '0;
            credits_d   = CRW'(ROB_DEPTH);
            ifl_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q         <= '0;
            credits_q      <= CRW'(ROB_DEPTH);
            ifl_valid_q    <= 1'b0;
            ifl_op_q       <= '0;
            ifl_imm_q      <= '0;
            ifl_rd_q       <= '0;
            ifl_robid_q    <= '0;
            ifl_rs1_zero_q <= 1'b0;
            ifl_rs2_zero_q <= 1'b0;
            ifl_wb_en_q    <= 1'b0;
            ifl_wb_idx_q   <= '0;
            ifl_wb_res_q   <= '0;
        end else begin
            tail_q         <= tail_d;
            credits_q      <= credits_d;
            ifl_valid_q    <= ifl_valid_d;
            ifl_op_q       <= ifl_op_d;
            ifl_imm_q      <= ifl_imm_d;
            ifl_rd_q       <= ifl_rd_d;
            ifl_robid_q    <= ifl_robid_d;
            ifl_rs1_zero_q <= ifl_rs1_zero_d;
            ifl_rs2_zero_q <= ifl_rs2_zero_d;
            ifl_wb_en_q    <= ifl_wb_en_d;
            ifl_wb_idx_q   <= ifl_wb_idx_d;
            ifl_wb_res_q   <= ifl_wb_res_d;
        end
    end

    rename_buf #(
        .OPW (OPW)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (rob_flush),
        .push_i       (ifl_valid_q),
        .push_op_i    (ifl_op_q),
        .push_imm_i   (ifl_imm_q),
        .push_rd_i    (ifl_rd_q),
        .push_robid_i (ifl_robid_q),
        .push_rs1_i   (cap_rs1),
        .push_rs2_i   (cap_rs2),
        .pop_i        (pop),
        .wb_en_i      (wb_en),
        .wb_idx_i     (wb_robid[ROB_IDXW-1:0]),
        .wb_result_i  (wb_result),
        .count_o      (buf_count),
        .head_valid_o (buf_valid),
        .head_op_o    (rename_dispatch_op),
        .head_imm_o   (rename_dispatch_imm),
        .head_rd_o    (rename_dispatch_rd),
        .head_robid_o (rename_dispatch_robid),
        .head_rs1_o   (head_rs1),
        .head_rs2_o   (head_rs2)
    );

    assign rename_dispatch_valid      = buf_valid;
    assign rename_dispatch_rs1_valid  = head_rs1.valid;
    assign rename_dispatch_rs1_tagval = head_rs1.tagval;
    assign rename_dispatch_rs2_valid  = head_rs2.valid;
    assign rename_dispatch_rs2_tagval = head_rs2.tagval;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: allocation, RAT capture, wakeup, credits, stalls and flush.
module tb_rename_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        decode_rename_valid;
    logic [7:0]  decode_rename_op;
    logic [4:0]  decode_rename_rs1, decode_rename_rs2;
    logic [5:0]  decode_rename_rd;
    logic [31:0] decode_rename_imm;
    logic        rename_stall, rename_rat_valid;
    logic [5:0]  rename_rat_rd;
    logic [7:0]  rename_rat_robid;
    logic [4:0]  rename_rat_rs1, rename_rat_rs2;
    logic        rat_rs1_valid, rat_rs2_valid;
    logic [31:0] rat_rs1_tagval, rat_rs2_tagval;
    logic        wb_valid, wb_error;
    logic [7:0]  wb_robid;
    logic [31:0] wb_result;
    logic        rob_flush, rob_ret_valid;
    logic        rename_dispatch_valid;
    logic [7:0]  rename_dispatch_op;
    logic [31:0] rename_dispatch_imm;
    logic [5:0]  rename_dispatch_rd;
    logic [7:0]  rename_dispatch_robid;
    logic        rename_dispatch_rs1_valid, rename_dispatch_rs2_valid;
    logic [31:0] rename_dispatch_rs1_tagval, rename_dispatch_rs2_tagval;
    logic        dispatch_stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rename_stage dut (
        .clk                        (clk),
        .rst                        (rst),
        .decode_rename_valid        (decode_rename_valid),
        .decode_rename_op           (decode_rename_op),
        .decode_rename_rs1          (decode_rename_rs1),
        .decode_rename_rs2          (decode_rename_rs2),
        .decode_rename_rd           (decode_rename_rd),
        .decode_rename_imm          (decode_rename_imm),
        .rename_stall               (rename_stall),
        .rename_rat_valid           (rename_rat_valid),
        .rename_rat_rd              (rename_rat_rd),
        .rename_rat_robid           (rename_rat_robid),
        .rename_rat_rs1             (rename_rat_rs1),
        .rename_rat_rs2             (rename_rat_rs2),
        .rat_rs1_valid              (rat_rs1_valid),
        .rat_rs1_tagval             (rat_rs1_tagval),
        .rat_rs2_valid              (rat_rs2_valid),
        .rat_rs2_tagval             (rat_rs2_tagval),
        .wb_valid                   (wb_valid),
        .wb_error                   (wb_error),
        .wb_robid                   (wb_robid),
        .wb_result                  (wb_result),
        .rob_flush                  (rob_flush),
        .rob_ret_valid              (rob_ret_valid),
        .rename_dispatch_valid      (rename_dispatch_valid),
        .rename_dispatch_op         (rename_dispatch_op),
        .rename_dispatch_imm        (rename_dispatch_imm),
        .rename_dispatch_rd         (rename_dispatch_rd),
        .rename_dispatch_robid      (rename_dispatch_robid),
        .rename_dispatch_rs1_valid  (rename_dispatch_rs1_valid),
        .rename_dispatch_rs1_tagval (rename_dispatch_rs1_tagval),
        .rename_dispatch_rs2_valid  (rename_dispatch_rs2_valid),
        .rename_dispatch_rs2_tagval (rename_dispatch_rs2_tagval),
        .dispatch_stall             (dispatch_stall)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        decode_rename_valid = 1'b0;
        decode_rename_op    = '0;
        decode_rename_rs1   = '0;
        decode_rename_rs2   = '0;
        decode_rename_rd    = '0;
        decode_rename_imm   = '0;
        rat_rs1_valid       = 1'b0;
        rat_rs1_tagval      = '0;
        rat_rs2_valid       = 1'b0;
        rat_rs2_tagval      = '0;
        wb_valid            = 1'b0;
        wb_error            = 1'b0;
        wb_robid            = '0;
        wb_result           = '0;
        rob_flush           = 1'b0;
        rob_ret_valid       = 1'b0;
    endtask

    initial begin
        idle();
        dispatch_stall = 1'b0;
        rst = 1'b1;
        decode_rename_valid = 1'b1;
        decode_rename_rd = 6'd3;
        repeat (2) tick();
        check_val("rst_stall", rename_stall, 1);
        check_val("rst_rat_valid", rename_rat_valid, 0);
        check_val("rst_rat_robid", rename_rat_robid, 0);
        check_val("rst_disp_valid", rename_dispatch_valid, 0);
        rst = 1'b0;
        idle();
        #1;
        check_val("post_rst_stall", rename_stall, 0);
        tick();

        // basic rename, ready operand
        decode_rename_valid = 1'b1;
        decode_rename_op = 8'hA5;
        decode_rename_rs1 = 5'd1;
        decode_rename_rs2 = 5'd2;
        decode_rename_rd = 6'd3;
        decode_rename_imm = 32'h1234;
        #1;
        check_val("t1_rat_valid", rename_rat_valid, 1);
        check_val("t1_rat_robid", rename_rat_robid, 8'h00);
        check_val("t1_rat_rs1", rename_rat_rs1, 5'd1);
        check_val("t1_rat_rd", rename_rat_rd, 6'd3);
        tick();
        idle();
        rat_rs1_valid = 1'b1;
        rat_rs1_tagval = 32'h55;
        rat_rs2_valid = 1'b1;
        rat_rs2_tagval = 32'h66;
        #1;
        check_val("t1_n1_disp_valid", rename_dispatch_valid, 0);
        tick();
        idle();
        #1;
        check_val("t1_disp_valid", rename_dispatch_valid, 1);
        check_val("t1_disp_robid", rename_dispatch_robid, 8'h00);
        check_val("t1_rs1_valid", rename_dispatch_rs1_valid, 1);
        check_val("t1_rs1_val", rename_dispatch_rs1_tagval, 32'h55);
        check_val("t1_disp_rd", rename_dispatch_rd, 6'd3);
        check_val("t1_disp_op", rename_dispatch_op, 8'hA5);
        check_val("t1_disp_imm", rename_dispatch_imm, 32'h1234);
        tick();
        check_val("t1_popped", rename_dispatch_valid, 0);

        // waiting operand woken in buffer while dispatch stalls; wb_error ignored
        decode_rename_valid = 1'b1;
        decode_rename_rs1 = 5'd7;
        decode_rename_rs2 = 5'd8;
        decode_rename_rd = 6'd4;
        dispatch_stall = 1'b1;
        #1;
        check_val("t2_rat_robid", rename_rat_robid, 8'h01);
        tick();
        idle();
        rat_rs1_valid = 1'b1;
        rat_rs1_tagval = 32'h11;
        rat_rs2_valid = 1'b0;
        rat_rs2_tagval = 32'hFFFF_FF05;
        tick();
        idle();
        wb_valid = 1'b1;
        wb_error = 1'b1;
        wb_robid = 8'h05;
        wb_result = 32'hBAD;
        #1;
        check_val("t2_head_valid", rename_dispatch_valid, 1);
        check_val("t2_head_robid", rename_dispatch_robid, 8'h01);
        check_val("t2_rs2_wait", rename_dispatch_rs2_valid, 0);
        check_val("t2_rs2_tag", rename_dispatch_rs2_tagval, 32'h05);
        tick();
        check_val("t2_err_nowake", rename_dispatch_rs2_valid, 0);
        wb_error = 1'b0;
        wb_result = 32'hDEAD;
        tick();
        idle();
        #1;
        check_val("t2_rs2_woken", rename_dispatch_rs2_valid, 1);
        check_val("t2_rs2_val", rename_dispatch_rs2_tagval, 32'hDEAD);
        check_val("t2_rs1_val", rename_dispatch_rs1_tagval, 32'h11);
        dispatch_stall = 1'b0;
        tick();
        check_val("t2_popped", rename_dispatch_valid, 0);

        // wb in cycle N (latched) and in N+1 (live) both wake the captured operands; no-dest instr
        decode_rename_valid = 1'b1;
        decode_rename_rs1 = 5'd3;
        decode_rename_rs2 = 5'd4;
        decode_rename_rd = 6'h20;
        wb_valid = 1'b1;
        wb_robid = 8'h07;
        wb_result = 32'hBEEF;
        #1;
        check_val("t3_nodest_rat_valid", rename_rat_valid, 0);
        check_val("t3_rat_robid", rename_rat_robid, 8'h02);
        tick();
        idle();
        rat_rs1_tagval = 32'h07;
        rat_rs2_tagval = 32'h09;
        wb_valid = 1'b1;
        wb_robid = 8'h89;
        wb_result = 32'hCAFE;
        tick();
        idle();
        #1;
        check_val("t3_rs1_valid", rename_dispatch_rs1_valid, 1);
        check_val("t3_rs1_val", rename_dispatch_rs1_tagval, 32'hBEEF);
        check_val("t3_rs2_valid", rename_dispatch_rs2_valid, 1);
        check_val("t3_rs2_val", rename_dispatch_rs2_tagval, 32'hCAFE);
        check_val("t3_disp_rd", rename_dispatch_rd, 6'h20);
        check_val("t3_disp_robid", rename_dispatch_robid, 8'h02);
        tick();

        // continuous stream into a stalled dispatch, then flush
        dispatch_stall = 1'b1;
        rat_rs1_valid = 1'b1;
        rat_rs2_valid = 1'b1;
        decode_rename_valid = 1'b1;
        decode_rename_rd = 6'd10;
        #1;
        check_val("t4_a0_stall", rename_stall, 0);
        check_val("t4_a0_robid", rename_rat_robid, 8'h03);
        tick();
        decode_rename_rd = 6'd11;
        #1;
        check_val("t4_a1_stall", rename_stall, 0);
        check_val("t4_a1_robid", rename_rat_robid, 8'h04);
        tick();
        decode_rename_rd = 6'd12;
        #1;
        check_val("t4_full_stall", rename_stall, 1);
        check_val("t4_head_valid", rename_dispatch_valid, 1);
        check_val("t4_head_robid3", rename_dispatch_robid, 8'h03);
        tick();
        check_val("t4_hold_stall", rename_stall, 1);
        check_val("t4_hold_robid3", rename_dispatch_robid, 8'h03);
        check_val("t4_hold_rd", rename_dispatch_rd, 6'd10);
        dispatch_stall = 1'b0;
        #1;
        check_val("t4_release_stall", rename_stall, 0);
        check_val("t4_release_robid", rename_rat_robid, 8'h05);
        tick();
        decode_rename_rd = 6'd13;
        #1;
        check_val("t4_head_robid4", rename_dispatch_robid, 8'h04);
        check_val("t4_head_rd11", rename_dispatch_rd, 6'd11);
        check_val("t4_pop_stall", rename_stall, 0);
        check_val("t4_rat_robid6", rename_rat_robid, 8'h06);
        tick();
        check_val("t4_head_robid5", rename_dispatch_robid, 8'h05);
        check_val("t4_head_rd12", rename_dispatch_rd, 6'd12);
        rob_flush = 1'b1;
        #1;
        check_val("t4_flush_stall", rename_stall, 1);
        check_val("t4_flush_rat_valid", rename_rat_valid, 0);
        tick();
        idle();
        #1;
        check_val("t4_flushed_empty", rename_dispatch_valid, 0);
        check_val("t4_flushed_tail", rename_rat_robid, 8'h00);

        // exhaust credits, wrap tail, one retire buys exactly one accept
        rat_rs1_valid = 1'b1;
        rat_rs2_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            decode_rename_valid = 1'b1;
            decode_rename_rd = 6'd1;
            #1;
            check_val("t5_stream_robid", rename_rat_robid, 64'(i));
            if (i == 2) begin
                check_val("t5_first_disp_robid", rename_dispatch_robid, 8'h00);
            end
            tick();
        end
        check_val("t5_no_credit_stall", rename_stall, 1);
        check_val("t5_no_credit_rat_valid", rename_rat_valid, 0);
        tick();
        rob_ret_valid = 1'b1;
        #1;
        check_val("t5_ret_cycle_stall", rename_stall, 1);
        tick();
        rob_ret_valid = 1'b0;
        #1;
        check_val("t5_one_credit_stall", rename_stall, 0);
        check_val("t5_wrap_robid", rename_rat_robid, 8'h80);
        check_val("t5_wrap_rat_valid", rename_rat_valid, 1);
        tick();
        check_val("t5_credit_gone_stall", rename_stall, 1);
        idle();
        repeat (3) tick();

`ifdef ZERO_REG_EN
        rob_flush = 1'b1;
        tick();
        idle();
        decode_rename_valid = 1'b1;
        decode_rename_rs1 = 5'd0;
        decode_rename_rs2 = 5'd5;
        decode_rename_rd = 6'd0;
        #1;
        check_val("z_rd0_rat_valid", rename_rat_valid, 0);
        tick();
        idle();
        rat_rs1_valid = 1'b0;
        rat_rs1_tagval = 32'h12;
        rat_rs2_valid = 1'b1;
        rat_rs2_tagval = 32'h77;
        tick();
        idle();
        #1;
        check_val("z_rs1_valid", rename_dispatch_rs1_valid, 1);
        check_val("z_rs1_val", rename_dispatch_rs1_tagval, 0);
        check_val("z_rs2_val", rename_dispatch_rs2_tagval, 32'h77);
        check_val("z_disp_rd", rename_dispatch_rd, 6'h20);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
